// File: rtl/seg_scan_ctrl_if.sv
// Display-word handshake between an upstream producer and seg_scan_ctrl.
//   din        new display word (packed digits, digit i at [M*i +: M])
//   din_valid  din is valid this cycle
//   din_ready  consumer can take a word this cycle
// master = producer side, slave = seg_scan_ctrl side.
interface seg_scan_ctrl_if #(
    parameter int unsigned W = 16
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed seven-segment display. Drives the select and
// packed data bus of a 2**S-to-1 digit mux, generates per-digit anode enables with a
// blank interval at the start of every slot, and swaps in new display words only at
// frame boundaries.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   en_i           scan enable; low = dark, scan position cleared
//   digit_en_i     per-digit mask; 0 = digit dark in its slot
//   din_if         display-word handshake (slave side)
//   disp_data_o    active display word to the mux data input
//   sel_o          current digit index to the mux select
//   an_o           anode drive, one-hot when driving, polarity per AN_LO
//   seg_blank_o    high when no anode is driven
//   frame_start_o  one-cycle pulse on the first cycle of slot 0
module seg_scan_ctrl #(
    parameter int unsigned S     = 2,
    parameter int unsigned M     = 4,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 1000,
    parameter bit          AN_LO = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [2**S-1:0]   digit_en_i,
    seg_scan_ctrl_if.slave    din_if,
    output logic [M*2**S-1:0] disp_data_o,
    output logic [S-1:0]      sel_o,
    output logic [2**S-1:0]   an_o,
    output logic              seg_blank_o,
    output logic              frame_start_o
);
    localparam int unsigned N  = 2**S;
    localparam int unsigned W  = M * N;
    localparam int unsigned CW = $clog2(DIV);
    localparam logic [N-1:0] AnOff = AN_LO ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    // With no blank interval every slot starts straight in DRIVE.
    localparam state_e StFirst = (BLANK == 0) ? StDrive : StBlank;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [S-1:0]  sel_q, sel_d;
    logic          fs_d;
    logic [N-1:0]  an_q, an_d;
    logic          blank_q, drive_d;
    logic          fs_q;
    logic          pending_q;
    logic [W-1:0]  shadow_q, disp_q;
    logic [N-1:0]  onehot;
    logic          accept;

    assign accept = din_if.din_valid && !pending_q;
    assign din_if.din_ready = !pending_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        fs_d    = 1'b0;
        if (!en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            sel_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StFirst;
                    cnt_d   = '0;
                    sel_d   = '0;
                    fs_d    = 1'b1;
                end
                default: begin
                    if (cnt_q == CW'(DIV - 1)) begin
                        cnt_d   = '0;
                        sel_d   = sel_q + 1'b1;
                        state_d = StFirst;
                        // Wrap from the last digit back to 0 marks a frame boundary.
                        fs_d    = (sel_q == S'(N - 1));
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == StBlank && cnt_d == CW'(BLANK)) begin
                            state_d = StDrive;
                        end
                    end
                end
            endcase
        end
        // Outputs are registered from the next state so they line up with cnt/sel.
        onehot  = N'(1) << sel_d;
        drive_d = (state_d == StDrive) && digit_en_i[sel_d];
        an_d    = drive_d ? (AN_LO ? ~onehot : onehot) : AnOff;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= '0;
            an_q      <= AnOff;
            blank_q   <= 1'b1;
            fs_q      <= 1'b0;
            pending_q <= 1'b0;
            shadow_q  <= '0;
            disp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            blank_q <= !drive_d;
            fs_q    <= fs_d;
            if (fs_d && pending_q) begin
                disp_q    <= shadow_q;
                pending_q <= 1'b0;
            end
            // Accept only happens with pending clear, so it never races the swap above.
            if (accept) begin
                shadow_q  <= din_if.din;
                pending_q <= 1'b1;
            end
        end
    end

    assign disp_data_o   = disp_q;
    assign sel_o         = sel_q;
    assign an_o          = an_q;
    assign seg_blank_o   = blank_q;
    assign frame_start_o = fs_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with S=2, M=4, DIV=8, BLANK=2, AN_LO=1.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  digit_en;
    logic [15:0] disp_data;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic        seg_blank;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int k      = 0;

    seg_scan_ctrl_if #(.W(16)) u_if ();

    seg_scan_ctrl #(
        .S(2), .M(4), .DIV(8), .BLANK(2), .AN_LO(1'b1)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .digit_en_i   (digit_en),
        .din_if       (u_if.slave),
        .disp_data_o  (disp_data),
        .sel_o        (sel),
        .an_o         (an),
        .seg_blank_o  (seg_blank),
        .frame_start_o(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference scan position derived from k = cycles since the enabling edge.
    task automatic model_check();
        int         cnt;
        int         sl;
        logic [3:0] oh;
        logic [3:0] exp_an;
        cnt    = k % 8;
        sl     = (k / 8) % 4;
        oh     = 4'b0001 << sl;
        exp_an = (cnt < 2 || !digit_en[sl]) ? 4'hF : ~oh;
        check_eq("sel", 32'(sel), 32'(sl));
        check_eq("an", 32'(an), 32'(exp_an));
        check_eq("seg_blank", 32'(seg_blank), 32'(exp_an == 4'hF));
        check_eq("frame_start", 32'(frame_start), 32'(k % 32 == 0));
    endtask

    task automatic step();
        tick();
        k++;
        model_check();
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b1;
        digit_en     = 4'hF;
        u_if.din       = 16'h0;
        u_if.din_valid = 1'b0;
        repeat (3) tick();
        check_eq("rst_an", 32'(an), 32'hF);
        check_eq("rst_sel", 32'(sel), 32'h0);
        check_eq("rst_blank", 32'(seg_blank), 32'h1);
        check_eq("rst_fs", 32'(frame_start), 32'h0);
        check_eq("rst_disp", 32'(disp_data), 32'h0);
        check_eq("rst_ready", 32'(u_if.din_ready), 32'h1);

        rst = 1'b0;
        tick();
        k = 0;
        model_check();

        // Word accepted in slot 1, held until the frame boundary.
        run_to(9);
        u_if.din       = 16'h1234;
        u_if.din_valid = 1'b1;
        step();
        u_if.din_valid = 1'b0;
        check_eq("acc_ready", 32'(u_if.din_ready), 32'h0);
        check_eq("acc_disp", 32'(disp_data), 32'h0);

        // Offered while pending: must be ignored.
        run_to(12);
        u_if.din       = 16'hABCD;
        u_if.din_valid = 1'b1;
        run_to(15);
        check_eq("pend_ready", 32'(u_if.din_ready), 32'h0);
        run_to(20);
        u_if.din_valid = 1'b0;
        run_to(31);
        check_eq("hold_disp", 32'(disp_data), 32'h0);
        step();
        check_eq("apply_disp", 32'(disp_data), 32'h1234);
        check_eq("apply_ready", 32'(u_if.din_ready), 32'h1);

        // Accept on the frame-start edge: applied one frame later.
        run_to(63);
        u_if.din       = 16'h5A5A;
        u_if.din_valid = 1'b1;
        step();
        u_if.din_valid = 1'b0;
        check_eq("fs_acc_disp", 32'(disp_data), 32'h1234);
        check_eq("fs_acc_ready", 32'(u_if.din_ready), 32'h0);
        run_to(95);
        check_eq("fs_acc_hold", 32'(disp_data), 32'h1234);

        // Mask digit 2 for one frame.
        digit_en = 4'b1011;
        step();
        check_eq("late_disp", 32'(disp_data), 32'h5A5A);
        check_eq("late_ready", 32'(u_if.din_ready), 32'h1);
        run_to(127);
        digit_en = 4'hF;

        // Pending word survives a disable, applied on re-enable.
        run_to(140);
        u_if.din       = 16'h7777;
        u_if.din_valid = 1'b1;
        step();
        u_if.din_valid = 1'b0;
        check_eq("p2_ready", 32'(u_if.din_ready), 32'h0);
        run_to(147);
        check_eq("pre_off_sel", 32'(sel), 32'h2);
        en = 1'b0;
        tick();
        check_eq("off_an", 32'(an), 32'hF);
        check_eq("off_sel", 32'(sel), 32'h0);
        check_eq("off_blank", 32'(seg_blank), 32'h1);
        check_eq("off_fs", 32'(frame_start), 32'h0);
        check_eq("off_ready", 32'(u_if.din_ready), 32'h0);
        check_eq("off_disp", 32'(disp_data), 32'h5A5A);
        tick();
        check_eq("off2_an", 32'(an), 32'hF);
        en = 1'b1;
        tick();
        k = 0;
        model_check();
        check_eq("reen_disp", 32'(disp_data), 32'h7777);
        check_eq("reen_ready", 32'(u_if.din_ready), 32'h1);

        // Reset mid-frame discards a pending word.
        run_to(20);
        u_if.din       = 16'h9999;
        u_if.din_valid = 1'b1;
        step();
        u_if.din_valid = 1'b0;
        check_eq("p3_ready", 32'(u_if.din_ready), 32'h0);
        rst = 1'b1;
        tick();
        check_eq("mrst_disp", 32'(disp_data), 32'h0);
        check_eq("mrst_ready", 32'(u_if.din_ready), 32'h1);
        check_eq("mrst_an", 32'(an), 32'hF);
        check_eq("mrst_sel", 32'(sel), 32'h0);
        check_eq("mrst_blank", 32'(seg_blank), 32'h1);
        check_eq("mrst_fs", 32'(frame_start), 32'h0);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        check_eq("post_disp", 32'(disp_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
